// File: rtl/cache_refill.sv
// Cache line-group refill engine: on a miss, reads the 4-word group from external memory and writes it into the cache data RAM.
// Latency: miss at T0 -> first o_ext_req at T2; zero-wait refill ends with o_wr_ready at T10, back in IDLE at T11.
// Backpressure: external memory stalls the refill by withholding i_ext_ack; REQ is held with stable request/address, no timeout.
//
// Ports:
//   i_clk, i_srst            clock, synchronous active-high reset
//   i_miss, i_addr           miss strobe and CPU word address (sampled in IDLE only)
//   i_load_addr              cache slot address from tag/LRU stage (sampled in LATCH only)
//   o_busy                   refill in progress (any state but IDLE)
//   o_ext_req/o_ext_addr     external read request and word address
//   i_ext_ack/i_ext_rdata    external acknowledge and read data (data valid in ack cycle)
//   o_ram_we/o_ram_addr/o_ram_wdata  cache data RAM write port
//   o_wr_ready               one-cycle pulse: group loaded
module cache_refill #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_srst,
  input  logic              i_miss,
  input  logic [29:0]       i_addr,
  input  logic [7:0]        i_load_addr,
  output logic              o_busy,
  output logic              o_ext_req,
  output logic [29:0]       o_ext_addr,
  input  logic              i_ext_ack,
  input  logic [DATA_W-1:0] i_ext_rdata,
  output logic              o_ram_we,
  output logic [7:0]        o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  output logic              o_wr_ready
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_REQ   = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  cnt;       // word index within the group, 0..3, never wraps inside a refill
  logic [27:0] ext_base;  // tag/block/group of the missing address
  logic [5:0]  ram_base;  // cache slot plus group offset within the slot

  // The word offsets of both addresses are deliberately dropped: a refill
  // always fetches the whole group starting at word 0.
  logic unused_word_bits;
  assign unused_word_bits = ^{i_addr[1:0], i_load_addr[1:0]};

  // State register
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (i_miss) state_nxt = ST_LATCH;
      ST_LATCH: state_nxt = ST_REQ;
      ST_REQ:   if (i_ext_ack) state_nxt = ST_WRITE;
      ST_WRITE: state_nxt = (cnt == 2'd3) ? ST_DONE : ST_REQ;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Datapath registers; each is only loaded in the one state that owns it,
  // so input changes outside that state cannot disturb an active refill.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      cnt         <= 2'd0;
      ext_base    <= 28'd0;
      ram_base    <= 6'd0;
      o_ram_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_miss) begin
            ext_base <= i_addr[29:2];
            cnt      <= 2'd0;
          end
        end
        ST_LATCH: ram_base <= i_load_addr[7:2];
        ST_REQ: begin
          if (i_ext_ack) o_ram_wdata <= i_ext_rdata;
        end
        ST_WRITE: begin
          if (cnt != 2'd3) cnt <= cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_ext_addr = {ext_base, cnt};
  assign o_ram_addr = {ram_base, cnt};

  // Output decode; strobes come from distinct states so they can never overlap.
  always_comb begin
    o_busy     = 1'b1;
    o_ext_req  = 1'b0;
    o_ram_we   = 1'b0;
    o_wr_ready = 1'b0;
    case (state)
      ST_IDLE:  o_busy     = 1'b0;
      ST_REQ:   o_ext_req  = 1'b1;
      ST_WRITE: o_ram_we   = 1'b1;
      ST_DONE:  o_wr_ready = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: doc/cache_refill.md
CACHE_REFILL -- requirements
Module: cache_refill

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the width of one cache data word.
REQ-002 i_clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 i_srst  input  1  SHALL be the synchronous, active-high reset.
REQ-004 i_miss  input  1  SHALL be the miss indication from the tag/LRU stage, where 1 = requested group not resident.
REQ-005 i_addr  input  30  SHALL be the CPU word address, laid out as tag[29:8], block[7:5], group[4:2], word[1:0].
REQ-006 i_load_addr  input  8  SHALL be the cache slot address from the tag/LRU stage: slot[7:5], word[4:0]; valid one cycle after i_miss.
REQ-007 o_busy  output  1  SHALL be high while a refill is in progress.
REQ-008 o_ext_req  output  1  SHALL be the external memory read request.
REQ-009 o_ext_addr  output  30  SHALL be the external memory word address.
REQ-010 i_ext_ack  input  1  SHALL be the external memory acknowledge; i_ext_rdata is valid in the ack cycle.
REQ-011 i_ext_rdata  input  DATA_W  SHALL be the external read data.
REQ-012 o_ram_we  output  1  SHALL be the cache data RAM write strobe.
REQ-013 o_ram_addr  output  8  SHALL be the cache data RAM address: slot[7:5], word[4:0].
REQ-014 o_ram_wdata  output  DATA_W  SHALL be the cache data RAM write data.
REQ-015 o_wr_ready  output  1  SHALL be a one-cycle pulse marking the group as loaded, driving the tag/LRU stage's i_wr_ready.

Function
REQ-016 The FSM SHALL have the states IDLE, LATCH, REQ, WRITE and DONE, all registered.
REQ-017 IDLE: on i_miss=1, capture i_addr[29:2] into ext_base, clear the 2-bit word counter cnt, and go to LATCH; otherwise stay in IDLE.
REQ-018 LATCH: capture i_load_addr[7:2] into ram_base and go to REQ.
REQ-019 REQ: o_ext_req=1 and o_ext_addr={ext_base,cnt}, both held stable until ack; on i_ext_ack=1, register i_ext_rdata into o_ram_wdata and go to WRITE.
REQ-020 WRITE: o_ram_we=1 for exactly one cycle with o_ram_addr={ram_base,cnt}.
REQ-021 WRITE exit: if cnt=3, go to DONE; otherwise increment cnt and go to REQ.
REQ-022 DONE: o_wr_ready=1 for one cycle, then go to IDLE.
REQ-023 o_busy SHALL be 1 in every state except IDLE.
REQ-024 Each refill SHALL write exactly 4 words, ordered word 0..3 of the group regardless of i_addr[1:0]; cnt SHALL NOT wrap within a refill.
REQ-025 With ack in the same cycle as the request, latency from the i_miss cycle (T0) SHALL be: first o_ext_req at T2, last o_ram_we at T9, o_wr_ready at T10, back to IDLE at T11.
REQ-026 Wait states SHALL extend REQ by one cycle per cycle without ack; there is no timeout.
REQ-027 i_miss SHALL be ignored in every state except IDLE, so no second refill is queued.
REQ-028 i_ext_ack SHALL be ignored outside REQ.
REQ-029 i_miss and i_addr SHALL be sampled only in IDLE, and i_load_addr only in LATCH; later changes SHALL NOT affect an active refill.
REQ-030 In the DONE cycle a new i_miss SHALL NOT be accepted; it is sampled in the following IDLE cycle.
REQ-031 o_ext_req, o_ram_we and o_wr_ready SHALL be mutually exclusive in every cycle.

Reset
REQ-032 When i_srst=1 at a clock edge, the block SHALL reset as follows: state=IDLE, cnt=0, ext_base=0, ram_base=0, o_ram_wdata=0, and o_busy, o_ext_req, o_ram_we and o_wr_ready all 0 from the next cycle.
REQ-033 i_srst SHALL take priority over all other inputs in any state.
REQ-034 If a refill is aborted by reset, no further o_ram_we or o_wr_ready SHALL occur for it, and a late i_ext_ack SHALL be ignored.

Verification
REQ-035 Zero-wait refill: i_miss at T0 with i_addr=0x0000_01A9 and i_load_addr=0x69 at T1, ack tied high. Required: o_ext_addr=0x1A8,0x1A9,0x1AA,0x1AB; o_ram_addr=0x68..0x6B at T3/T5/T7/T9; o_wr_ready at T10 only.
REQ-036 Wait states: ack delayed 3 cycles on word 1. Required: o_ext_req and o_ext_addr=0x1A9 held for 4 cycles; the data written is the value present in the ack cycle.
REQ-037 Data integrity: rdata = 0xA0A0_0000+cnt. Required: RAM receives 0xA0A0_0000..0xA0A0_0003 in order, one o_ram_we pulse each.
REQ-038 Miss while busy: i_miss toggled during refill and held high in DONE. Required: exactly one refill completes, then a new refill starts from IDLE at DONE+1.
REQ-039 Reset mid-refill: i_srst after word 1 is written, then a spurious ack. Required: all outputs 0 from the next cycle, no o_wr_ready, and a fresh miss runs a full 4-word refill.
REQ-040 Stray ack in IDLE: i_ext_ack=1 with i_miss=0. Required: no o_ram_we, no o_wr_ready, and o_busy stays 0.
